// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_ctrl_if
//
// Purpose: register-bus and CP0 handshake bundle for irq_ctrl.
//
// Signals:
//   address  bridge address; irq_ctrl decodes only bits [3:2]
//   WE_I     register write strobe
//   DAT_I    write data
//   DAT_O    read data, combinational from address[3:2]
//   INT_ACK  one-cycle pulse from CP0 when it takes the interrupt
//   IRQ      registered interrupt request to CP0
//   HWINT    pending & MASK, for the CP0 Cause.IP field
//   CUR_ID   ID of the source being requested or serviced
//
// Modports:
//   master   bus master / CP0 side
//   slave    the interrupt controller
// ---------------------------------------------------------------------------
interface irq_ctrl_if #(
    parameter int N_SRC = 6
);
    logic [31:0]      address;
    logic             WE_I;
    logic [31:0]      DAT_I;
    logic [31:0]      DAT_O;
    logic             INT_ACK;
    logic             IRQ;
    logic [N_SRC-1:0] HWINT;
    logic [2:0]       CUR_ID;

    modport master (
        output address, WE_I, DAT_I, INT_ACK,
        input  DAT_O, IRQ, HWINT, CUR_ID
    );

    modport slave (
        input  address, WE_I, DAT_I, INT_ACK,
        output DAT_O, IRQ, HWINT, CUR_ID
    );
endinterface

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
//
// Purpose: interrupt controller sitting behind the Timer and other bridge
// devices. Each device line is latched into a pending bit (edge or level
// mode per source), gated by a per-source mask, and the lowest-index active
// source is presented to CP0 through a request / ack / end-of-interrupt
// handshake.
//
// Ports:
//   CLK_I    system clock, rising edge
//   RST_I    asynchronous active-low reset
//   IRQ_SRC  device interrupt lines [N_SRC-1:0]
//   bus      irq_ctrl_if.slave: address, WE_I, DAT_I, DAT_O, INT_ACK,
//            IRQ, HWINT, CUR_ID
//
// Register map (address[3:2]):
//   0 MASK     RW  1 = source enabled
//   1 MODE     RW  1 = edge, 0 = level
//   2 PENDING  RO  write-1-to-clear of edge-mode bits
//   3 STATUS   RO  {busy[31], state[9:8], CUR_ID[2:0]}; any write is EOI
//
// Build option:
//   IRQ_SYNC_EN  when defined, every IRQ_SRC bit goes through a two-flop
//                synchronizer before edge detection / level sampling,
//                adding two cycles to all source latencies.
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [N_SRC-1:0] IRQ_SRC,
    irq_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Architectural registers
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] src_d;
    state_t           state_q;
    logic [2:0]       cur_id_q;
    logic             irq_q;

    // Next-state values
    state_t           state_d;
    logic [2:0]       cur_id_d;
    logic             irq_d;
    logic [N_SRC-1:0] pending_d;

    // Source sampling point (optionally synchronized)
    logic [N_SRC-1:0] src_s;

    // Decode / selection helpers
    logic [1:0]       word_sel;
    logic             wr_mask;
    logic             wr_mode;
    logic             wr_pend;
    logic             wr_status;
    logic [N_SRC-1:0] act;
    logic [2:0]       sel;
    logic             any;
    logic [N_SRC-1:0] cur_oh;
    logic             cur_act;
    logic             ack_take;
    logic             busy;
    logic [31:0]      rd_data;

    // -----------------------------------------------------------------------
    // Source conditioning
    // -----------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] src_sync_p0;
    logic [N_SRC-1:0] src_sync_p1;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            src_sync_p0 <= '0;
            src_sync_p1 <= '0;
        end else begin
            src_sync_p0 <= IRQ_SRC;
            src_sync_p1 <= src_sync_p0;
        end
    end

    assign src_s = src_sync_p1;
`else
    assign src_s = IRQ_SRC;
`endif

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    assign word_sel  = bus.address[3:2];
    assign wr_mask   = bus.WE_I && (word_sel == 2'd0);
    assign wr_mode   = bus.WE_I && (word_sel == 2'd1);
    assign wr_pend   = bus.WE_I && (word_sel == 2'd2);
    assign wr_status = bus.WE_I && (word_sel == 2'd3);

    // Only address[3:2] and DAT_I[N_SRC-1:0] carry meaning.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.address[31:4], bus.address[1:0], bus.DAT_I};

    // -----------------------------------------------------------------------
    // Priority selection: lowest active index wins
    // -----------------------------------------------------------------------
    assign act = pending & mask;

    always_comb begin
        sel = 3'd0;
        any = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                sel = 3'(i);
                any = 1'b1;
            end
        end
    end

    // One-hot of the latched ID; built by comparison so CUR_ID values beyond
    // N_SRC-1 simply select nothing.
    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cur_id_q == 3'(i)) begin
                cur_oh[i] = 1'b1;
            end
        end
    end

    assign cur_act = |(act & cur_oh);

    // -----------------------------------------------------------------------
    // Handshake FSM: next state / outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        irq_d    = irq_q;
        ack_take = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    cur_id_d = sel;
                    irq_d    = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // A withdrawn request beats an ACK arriving in the same cycle.
                if (!cur_act) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (bus.INT_ACK) begin
                    irq_d    = 1'b0;
                    ack_take = 1'b1;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                irq_d = 1'b0;
                if (wr_status) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pending next value
    // -----------------------------------------------------------------------
    // Edge bits: a fresh rising edge overrides any clear in the same cycle.
    // Level bits: simply track the sampled source.
    always_comb begin
        logic [N_SRC-1:0] rise;
        logic [N_SRC-1:0] clr;
        logic [N_SRC-1:0] edge_next;
        rise      = src_s & ~src_d;
        clr       = (wr_pend ? bus.DAT_I[N_SRC-1:0] : '0) | (ack_take ? cur_oh : '0);
        edge_next = rise | (pending & ~clr);
        pending_d = (mode & edge_next) | (~mode & src_s);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= ST_IDLE;
            cur_id_q <= 3'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            mask    <= '0;
            mode    <= '0;
            pending <= '0;
            src_d   <= '0;
        end else begin
            if (wr_mask) begin
                mask <= bus.DAT_I[N_SRC-1:0];
            end
            if (wr_mode) begin
                mode <= bus.DAT_I[N_SRC-1:0];
            end
            pending <= pending_d;
            src_d   <= src_s;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and outputs
    // -----------------------------------------------------------------------
    assign busy = (state_q != ST_IDLE);

    always_comb begin
        rd_data = '0;
        unique case (word_sel)
            2'd0: rd_data[N_SRC-1:0] = mask;
            2'd1: rd_data[N_SRC-1:0] = mode;
            2'd2: rd_data[N_SRC-1:0] = pending;
            2'd3: rd_data = {busy, 21'd0, state_q, 5'd0, cur_id_q};
            default: rd_data = '0;
        endcase
    end

    assign bus.DAT_O  = rd_data;
    assign bus.HWINT  = act;
    assign bus.IRQ    = irq_q;
    assign bus.CUR_ID = cur_id_q;

endmodule
